spi_master_tx: RTL

SPI initiator. Generates SCLK, CS_N and MOSI, and captures MISO, for one DATA_WIDTH-bit full-duplex word per start request. It drives the off-chip or peer SPI responder, whose edge detectors sample the SCLK it produces. Host side uses a start/busy/done handshake.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/spi_master_tx_if.sv | 30 +++
 rtl/spi_clk_div.sv | 42 ++++
 rtl/spi_master_tx.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator.
//   spi_state_e   : transfer FSM states
//   SPI_MODE0..3  : {CPOL, CPHA} encodings of the four SPI modes
//   clog2()       : ceiling log2 for sizing counters (never returns 0)
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD,
        ST_DONE
    } spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        int unsigned reach;
        bits  = 0;
        reach = 1;
        while (reach < value) begin
            reach = reach << 1;
            bits  = bits + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Host handshake plus SPI pin bundle for spi_master_tx.
//   start/tx_data      : host transfer request and word to send
//   busy/done/rx_data  : transfer status and received word
//   sclk/mosi/cs_n     : SPI pins driven by the initiator
//   miso               : SPI pin driven by the responder
// Modport master is the initiator's view; slave is the view of whatever surrounds it
// (host logic and the off-chip responder).
interface spi_master_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  cs_n;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, cs_n
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, cs_n
    );
endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period timer.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : run enable; the count clears whenever en is low
//   tick : one-cycle pulse every CLK_DIV cycles while en is high
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned CntW = clog2(CLK_DIV + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // First tick lands CLK_DIV cycles after en rises; with CLK_DIV=1 it ticks every cycle.
    assign tick = en && (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI initiator: one full-duplex DATA_WIDTH-bit word, MSB first, per accepted start.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_master_tx_if.master
//              start/tx_data in, busy/done/rx_data out (host side)
//              sclk/mosi/cs_n out, miso in (SPI side)
// All outputs come straight from flops. State sequence IDLE-SETUP-XFER-HOLD-DONE; SETUP,
// each SCLK half-period and HOLD all last CLK_DIV cycles.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_DIV    = 2,
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0
) (
    input logic             clk,
    input logic             rst,
    spi_master_tx_if.master bus
);

    localparam int unsigned      NumEdges = 2 * DATA_WIDTH;
    localparam int unsigned      EdgeW    = clog2(NumEdges + 1);
    localparam logic [EdgeW-1:0] EdgeEnd  = EdgeW'(NumEdges);
    localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(NumEdges - 1);
    // Modes 0 and 2 sample on the leading edge, modes 1 and 3 on the trailing edge.
    localparam bit SampleLead = ({CPOL, CPHA} == SPI_MODE0) || ({CPOL, CPHA} == SPI_MODE2);

    spi_state_e            state_q, state_d;
    logic                  tick, div_en;
    logic                  edge_fire, lead_edge, sample_edge, shift_edge;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [EdgeW-1:0]      edge_q, edge_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    assign div_en = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk (clk),
        .rst (rst),
        .en  (div_en),
        .tick(tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. XFER stays one half-period past the last edge so the final SCLK level
    // lasts as long as the others before HOLD begins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_XFER;
            ST_XFER:  if (tick && (edge_q == EdgeEnd)) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // SCLK edge decode. The tick ending SETUP produces edge 0; edge_q counts edges issued.
    always_comb begin
        edge_fire   = tick && ((state_q == ST_SETUP) ||
                               ((state_q == ST_XFER) && (edge_q != EdgeEnd)));
        lead_edge   = ~edge_q[0];
        sample_edge = edge_fire && (lead_edge == SampleLead);
        // Leading-edge samplers have no bit left to present after the final trailing edge.
        shift_edge  = edge_fire && (lead_edge != SampleLead) &&
                      !(SampleLead && (edge_q == EdgeLast));
    end

    // Output / datapath next values. A single register shifts left: miso enters at the LSB
    // on sampling edges, and the MSB is then the next bit to present on mosi.
    always_comb begin
        sreg_d    = sreg_q;
        edge_d    = edge_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        rx_data_d = rx_data_q;
        cs_n_d    = !((state_d == ST_SETUP) || (state_d == ST_XFER) || (state_d == ST_HOLD));
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);

        if (state_q == ST_IDLE) begin
            sclk_d = CPOL;
            edge_d = '0;
            if (bus.start) begin
                sreg_d = bus.tx_data;
                if (!CPHA) begin
                    mosi_d = bus.tx_data[DATA_WIDTH-1];
                end
            end
        end

        if (edge_fire) begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + EdgeW'(1);
        end

        // miso is taken on the clk edge that launches the sampling SCLK transition.
        if (sample_edge) begin
            sreg_d = {sreg_q[DATA_WIDTH-2:0], bus.miso};
        end

        if (shift_edge) begin
            mosi_d = sreg_q[DATA_WIDTH-1];
        end

        if ((state_q == ST_HOLD) && tick) begin
            rx_data_d = sreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q    <= '0;
            edge_q    <= '0;
            sclk_q    <= CPOL;
            mosi_q    <= 1'b0;
            rx_data_q <= '0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            sreg_q    <= sreg_d;
            edge_q    <= edge_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            rx_data_q <= rx_data_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

endmodule
